// File: rtl/bus_master_arbiter_pkg.sv
// Shared encodings for the three-master bus arbiter: request kinds, FSM states,
// master indices and small decode helpers.
package bus_master_arbiter_pkg;

   localparam logic [1:0] ARB_KIND_READ  = 2'b00;
   localparam logic [1:0] ARB_KIND_WRITE = 2'b01;
   localparam logic [1:0] ARB_KIND_MSG   = 2'b10;

   localparam logic [1:0] ARB_M_MEM  = 2'd0;
   localparam logic [1:0] ARB_M_THRD = 2'd1;
   localparam logic [1:0] ARB_M_CHAN = 2'd2;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_WAIT    = 2'd1,
      ARB_MSG     = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_e;

   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      logic [1:0] idx;
      case (oh)
         3'b010:  idx = ARB_M_THRD;
         3'b100:  idx = ARB_M_CHAN;
         default: idx = ARB_M_MEM;
      endcase
      return idx;
   endfunction

   // Any kind with the upper bit set is a message, whatever the low bit holds.
   function automatic logic kind_is_msg(input logic [1:0] kind);
      return (kind & ARB_KIND_MSG) != 2'b00;
   endfunction

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Request/grant and bus-pin bundle between the three masters and the arbiter.
interface bus_master_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  clk_oe;
   logic                  bus_busy;
   logic [2:0]            req;
   logic [5:0]            req_kind;
   logic [3*ADDR_W-1:0]   req_addr;
   logic [3*DATA_W-1:0]   req_data;
   logic                  read_dn;
   logic                  write_dn;
   logic [2:0]            gnt;
   logic [2:0]            done;
   logic                  timeout_err;
   logic [ADDR_W-1:0]     addr_out;
   logic [DATA_W-1:0]     data_out;
   logic                  read_q;
   logic                  write_q;
   logic                  msg_pulse;

   modport slave (
      input  clk_oe, bus_busy, req, req_kind, req_addr, req_data, read_dn, write_dn,
      output gnt, done, timeout_err, addr_out, data_out, read_q, write_q, msg_pulse
   );

   modport master (
      output req, req_kind, req_addr, req_data,
      input  gnt, done, timeout_err
   );
endinterface

// File: rtl/bus_master_arbiter_rr_pick3.sv
// Three-way round-robin picker: the first set request after the pointer wins.
module rr_pick3
   import bus_master_arbiter_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic [1:0] ptr_i,
   output logic [2:0] win_o
);

   // Search order starts one past the pointer and wraps modulo three.
   always_comb begin
      win_o = 3'b000;
      case (ptr_i)
         ARB_M_MEM: begin
            if (req_i[ARB_M_THRD])      win_o = 3'b010;
            else if (req_i[ARB_M_CHAN]) win_o = 3'b100;
            else if (req_i[ARB_M_MEM])  win_o = 3'b001;
            else                        win_o = 3'b000;
         end
         ARB_M_THRD: begin
            if (req_i[ARB_M_CHAN])      win_o = 3'b100;
            else if (req_i[ARB_M_MEM])  win_o = 3'b001;
            else if (req_i[ARB_M_THRD]) win_o = 3'b010;
            else                        win_o = 3'b000;
         end
         default: begin
            if (req_i[ARB_M_MEM])       win_o = 3'b001;
            else if (req_i[ARB_M_THRD]) win_o = 3'b010;
            else if (req_i[ARB_M_CHAN]) win_o = 3'b100;
            else                        win_o = 3'b000;
         end
      endcase
   end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin owner of the internal address/data bus: grants one master at a time,
// sequences read/write/message handshakes, and aborts stuck transfers on timeout.
module bus_master_arbiter
   import bus_master_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic                 clk,
   input logic                 rst,
   bus_master_arbiter_if.slave bus
);

   localparam int               CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

   arb_state_e       state_q;
   logic [1:0]       ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       gnt_q;
   logic [2:0]       done_q;
   logic             tmo_q;
   logic             rd_q;
   logic             wr_q;
   logic             msg_q;

   logic [2:0]        win_oh_s;
   logic [1:0]        win_idx_s;
   logic [1:0]        win_kind_s;
   logic              dn_match_s;
   logic              held_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] data_s;

   rr_pick3 u_pick (
      .req_i (bus.req),
      .ptr_i (ptr_q),
      .win_o (win_oh_s)
   );

   assign win_idx_s  = onehot_to_idx(win_oh_s);
   assign win_kind_s = bus.req_kind[{win_idx_s, 1'b0} +: 2];
   assign dn_match_s = (rd_q & bus.read_dn) | (wr_q & bus.write_dn);
   assign held_s     = (bus.req & gnt_q) != 3'b000;
   assign cnt_d      = (cnt_q == TMO_C) ? cnt_q : cnt_q + 1'b1;

   // Address/data follow the grant but are forced to zero outside an active strobe.
   always_comb begin
      addr_s = {ADDR_W{1'b0}};
      data_s = {DATA_W{1'b0}};
      if (rd_q | wr_q | msg_q) begin
         case (gnt_q)
            3'b001: begin
               addr_s = bus.req_addr[0 +: ADDR_W];
               data_s = bus.req_data[0 +: DATA_W];
            end
            3'b010: begin
               addr_s = bus.req_addr[ADDR_W +: ADDR_W];
               data_s = bus.req_data[DATA_W +: DATA_W];
            end
            3'b100: begin
               addr_s = bus.req_addr[2*ADDR_W +: ADDR_W];
               data_s = bus.req_data[2*DATA_W +: DATA_W];
            end
            default: begin
               addr_s = {ADDR_W{1'b0}};
               data_s = {DATA_W{1'b0}};
            end
         endcase
      end else begin
         addr_s = {ADDR_W{1'b0}};
         data_s = {DATA_W{1'b0}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         ptr_q   <= ARB_M_CHAN;
         cnt_q   <= {CNT_W{1'b0}};
         gnt_q   <= 3'b000;
         done_q  <= 3'b000;
         tmo_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         msg_q   <= 1'b0;
      end else if (bus.clk_oe) begin
         done_q <= 3'b000;
         tmo_q  <= 1'b0;
         msg_q  <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (!bus.bus_busy && (bus.req != 3'b000)) begin
                  gnt_q <= win_oh_s;
                  ptr_q <= win_idx_s;
                  cnt_q <= {CNT_W{1'b0}};
                  if (kind_is_msg(win_kind_s)) begin
                     msg_q   <= 1'b1;
                     state_q <= ARB_MSG;
                  end else if (win_kind_s == ARB_KIND_READ) begin
                     rd_q    <= 1'b1;
                     state_q <= ARB_WAIT;
                  end else begin
                     wr_q    <= 1'b1;
                     state_q <= ARB_WAIT;
                  end
               end else begin
                  state_q <= ARB_IDLE;
               end
            end
            ARB_WAIT: begin
               cnt_q <= cnt_d;
               // A matching completion wins over a timeout landing on the same edge.
               if (dn_match_s) begin
                  done_q  <= gnt_q;
                  gnt_q   <= 3'b000;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  state_q <= ARB_RELEASE;
               end else if (!held_s) begin
                  gnt_q   <= 3'b000;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  state_q <= ARB_RELEASE;
               end else if (cnt_d == TMO_C) begin
                  done_q  <= gnt_q;
                  tmo_q   <= 1'b1;
                  gnt_q   <= 3'b000;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  state_q <= ARB_RELEASE;
               end else begin
                  state_q <= ARB_WAIT;
               end
            end
            ARB_MSG: begin
               done_q  <= gnt_q;
               gnt_q   <= 3'b000;
               state_q <= ARB_RELEASE;
            end
            ARB_RELEASE: begin
               gnt_q   <= 3'b000;
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               state_q <= ARB_IDLE;
            end
            default: begin
               gnt_q   <= 3'b000;
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = tmo_q;
   assign bus.read_q      = rd_q;
   assign bus.write_q     = wr_q;
   assign bus.msg_pulse   = msg_q;
   assign bus.addr_out    = addr_s;
   assign bus.data_out    = data_s;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Scoreboard bench for bus_master_arbiter: directed transfers push expected output
// events (with cycle stamps); a negedge monitor detects events and compares them.
module tb_bus_master_arbiter;
   import bus_master_arbiter_pkg::*;

   localparam logic [1:0] EV_GNT  = 2'd0;
   localparam logic [1:0] EV_DONE = 2'd1;
   localparam logic [1:0] EV_DEND = 2'd2;
   localparam logic [1:0] EV_DROP = 2'd3;

   localparam logic [31:0] A0 = 32'h0000_0040;
   localparam logic [31:0] A1 = 32'h0000_1100;
   localparam logic [31:0] A2 = 32'h0000_2200;
   localparam logic [31:0] D0 = 32'hDEAD_0000;
   localparam logic [31:0] D1 = 32'h1111_1111;
   localparam logic [31:0] D2 = 32'h2222_2222;

   typedef struct packed {
      logic [1:0]  ev;
      logic [2:0]  gnt;
      logic [2:0]  done;
      logic        tmo;
      logic        rd;
      logic        wr;
      logic        msg;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_miss = 0;
   bit   mon_en = 1'b0;
   ev_t  exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bus_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   bus_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic void push(input logic [1:0] ev, input logic [2:0] g, input logic [2:0] d,
                                input logic t, input logic r, input logic w, input logic m,
                                input logic [31:0] a, input logic [31:0] dt, input int c);
      ev_t e;
      e.ev = ev; e.gnt = g; e.done = d; e.tmo = t; e.rd = r; e.wr = w; e.msg = m;
      e.addr = a; e.data = dt; e.cyc = c;
      exp_q.push_back(e);
   endfunction

   function automatic void exp_gnt(input logic [2:0] g, input logic r, input logic w, input logic m,
                                   input logic [31:0] a, input logic [31:0] dt, input int c);
      push(EV_GNT, g, 3'b000, 1'b0, r, w, m, a, dt, c);
   endfunction

   // Completion: done rises at cr with everything else quiet, and falls at cf.
   function automatic void exp_done(input logic [2:0] d, input logic t, input int cr, input int cf);
      push(EV_DONE, 3'b000, d, t, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cr);
      push(EV_DEND, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cf);
   endfunction

   function automatic void exp_drop(input int c);
      push(EV_DROP, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, c);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: classify each output change as an event and score it against the queue.
   logic [2:0] prev_gnt = 3'b000;
   logic [2:0] prev_done = 3'b000;
   bit         started = 1'b0;
   ev_t        cur;
   ev_t        want;
   bit         found;
   always @(negedge clk) begin
      if (mon_en) begin
         cur.gnt = bus.gnt; cur.done = bus.done; cur.tmo = bus.timeout_err;
         cur.rd = bus.read_q; cur.wr = bus.write_q; cur.msg = bus.msg_pulse;
         cur.addr = bus.addr_out; cur.data = bus.data_out; cur.cyc = cyc;
         cur.ev = EV_GNT;
         if (!started) begin
            started = 1'b1;
            n_chk++;
            if ({cur.gnt, cur.done, cur.tmo, cur.rd, cur.wr, cur.msg, cur.addr, cur.data} == 76'h0)
               n_pass++;
            else
               $display("FAIL reset_state: got gnt=%b done=%b tmo=%b rd=%b wr=%b msg=%b addr=%h data=%h, want all zero",
                        cur.gnt, cur.done, cur.tmo, cur.rd, cur.wr, cur.msg, cur.addr, cur.data);
         end
         found = 1'b1;
         if (bus.done != 3'b000 && prev_done == 3'b000)      cur.ev = EV_DONE;
         else if (bus.done == 3'b000 && prev_done != 3'b000) cur.ev = EV_DEND;
         else if (bus.gnt != 3'b000 && prev_gnt == 3'b000)   cur.ev = EV_GNT;
         else if (bus.gnt == 3'b000 && prev_gnt != 3'b000)   cur.ev = EV_DROP;
         else                                                found = 1'b0;
         if (found) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_event: got ev=%0d cyc=%0d gnt=%b done=%b tmo=%b, want none",
                        cur.ev, cur.cyc, cur.gnt, cur.done, cur.tmo);
            end else begin
               want = exp_q.pop_front();
               if (cur == want) n_pass++;
               else
                  $display("FAIL event: got ev=%0d cyc=%0d gnt=%b done=%b tmo=%b rd=%b wr=%b msg=%b addr=%h data=%h; want ev=%0d cyc=%0d gnt=%b done=%b tmo=%b rd=%b wr=%b msg=%b addr=%h data=%h",
                           cur.ev, cur.cyc, cur.gnt, cur.done, cur.tmo, cur.rd, cur.wr, cur.msg, cur.addr, cur.data,
                           want.ev, want.cyc, want.gnt, want.done, want.tmo, want.rd, want.wr, want.msg, want.addr, want.data);
            end
         end
         prev_gnt  = bus.gnt;
         prev_done = bus.done;
      end
   end

   int c0;
   initial begin
      bus.clk_oe   = 1'b1;
      bus.bus_busy = 1'b0;
      bus.req      = 3'b000;
      bus.req_kind = 6'b000000;
      bus.req_addr = {A2, A1, A0};
      bus.req_data = {D2, D1, D0};
      bus.read_dn  = 1'b0;
      bus.write_dn = 1'b0;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      mon_en = 1'b1;
      step(2);

      // All three masters send messages: strict rotation, one grant every 3 cycles.
      c0 = cyc;
      bus.req_kind = {2'b11, ARB_KIND_MSG, ARB_KIND_MSG};
      bus.req = 3'b111;
      exp_gnt(3'b001, 1'b0, 1'b0, 1'b1, A0, D0, c0 + 1);  exp_done(3'b001, 1'b0, c0 + 2, c0 + 3);
      exp_gnt(3'b010, 1'b0, 1'b0, 1'b1, A1, D1, c0 + 4);  exp_done(3'b010, 1'b0, c0 + 5, c0 + 6);
      exp_gnt(3'b100, 1'b0, 1'b0, 1'b1, A2, D2, c0 + 7);  exp_done(3'b100, 1'b0, c0 + 8, c0 + 9);
      exp_gnt(3'b001, 1'b0, 1'b0, 1'b1, A0, D0, c0 + 10); exp_done(3'b001, 1'b0, c0 + 11, c0 + 12);
      step(11);
      bus.req = 3'b000;
      step(3);

      // Memory manager read at 0x40, read_dn four cycles after the request.
      c0 = cyc;
      bus.req_kind = {ARB_KIND_READ, ARB_KIND_READ, ARB_KIND_READ};
      bus.req = 3'b001;
      exp_gnt(3'b001, 1'b1, 1'b0, 1'b0, A0, D0, c0 + 1);
      exp_done(3'b001, 1'b0, c0 + 5, c0 + 6);
      step(4);
      bus.read_dn = 1'b1;
      step(1);
      bus.read_dn = 1'b0;
      bus.req = 3'b000;
      step(3);

      // Channel controller write that never completes: abort after 8 WAIT cycles.
      c0 = cyc;
      bus.req_kind = {ARB_KIND_WRITE, ARB_KIND_READ, ARB_KIND_READ};
      bus.req = 3'b100;
      exp_gnt(3'b100, 1'b0, 1'b1, 1'b0, A2, D2, c0 + 1);
      exp_done(3'b100, 1'b1, c0 + 9, c0 + 10);
      step(9);
      bus.req = 3'b000;
      step(3);

      // Read whose read_dn lands on the timeout edge; a stray write_dn is ignored.
      c0 = cyc;
      bus.req_kind = {ARB_KIND_READ, ARB_KIND_READ, ARB_KIND_READ};
      bus.req = 3'b001;
      exp_gnt(3'b001, 1'b1, 1'b0, 1'b0, A0, D0, c0 + 1);
      exp_done(3'b001, 1'b0, c0 + 9, c0 + 10);
      step(2);
      bus.write_dn = 1'b1;
      step(1);
      bus.write_dn = 1'b0;
      step(5);
      bus.read_dn = 1'b1;
      step(1);
      bus.read_dn = 1'b0;
      bus.req = 3'b000;
      step(3);

      // Thread controller abandons its read: grant drops with no done.
      c0 = cyc;
      bus.req = 3'b010;
      exp_gnt(3'b010, 1'b1, 1'b0, 1'b0, A1, D1, c0 + 1);
      exp_drop(c0 + 3);
      step(2);
      bus.req = 3'b000;
      step(3);

      // bus_busy holds off the grant until one cycle after it falls.
      c0 = cyc;
      bus.bus_busy = 1'b1;
      bus.req = 3'b010;
      exp_gnt(3'b010, 1'b1, 1'b0, 1'b0, A1, D1, c0 + 4);
      exp_done(3'b010, 1'b0, c0 + 6, c0 + 7);
      step(3);
      bus.bus_busy = 1'b0;
      step(2);
      bus.read_dn = 1'b1;
      step(1);
      bus.read_dn = 1'b0;
      bus.req = 3'b000;
      step(3);

      // clk_oe alternates: read_dn on a disabled edge is ignored, done spans one enabled cycle.
      c0 = cyc;
      bus.req = 3'b001;
      exp_gnt(3'b001, 1'b1, 1'b0, 1'b0, A0, D0, c0 + 1);
      exp_done(3'b001, 1'b0, c0 + 7, c0 + 9);
      step(1);
      for (int j = 1; j <= 9; j++) begin
         bus.clk_oe  = (j % 2 == 0);
         bus.read_dn = (j == 3 || j == 6);
         if (j == 7) bus.req = 3'b000;
         step(1);
      end
      bus.clk_oe  = 1'b1;
      bus.read_dn = 1'b0;
      step(3);

      // Reset during WAIT, then the same request is granted again from reset state.
      c0 = cyc;
      bus.req = 3'b001;
      exp_gnt(3'b001, 1'b1, 1'b0, 1'b0, A0, D0, c0 + 1);
      exp_drop(c0 + 3);
      exp_gnt(3'b001, 1'b1, 1'b0, 1'b0, A0, D0, c0 + 4);
      exp_done(3'b001, 1'b0, c0 + 6, c0 + 7);
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      bus.read_dn = 1'b1;
      step(1);
      bus.read_dn = 1'b0;
      bus.req = 3'b000;
      step(5);

      n_miss = exp_q.size();
      for (int k = 0; k < n_miss; k++)
         $display("FAIL missing_event: got nothing, want ev=%0d at cyc=%0d", exp_q[k].ev, exp_q[k].cyc);
      $display("%0d/%0d checks passed", n_pass, n_chk + n_miss);
      $finish;
   end

endmodule

// File: doc/bus_master_arbiter.md
# bus_master_arbiter

Registered arbiter for the CPU-internal address/data bus. It is shared by three masters: the memory manager, the thread controller and the channel controller. Instead of OR-ing the masters' address/data outputs together, it grants the bus to exactly one master at a time, round-robin. It sequences the read/write/message handshake, returns a per-master completion pulse, and aborts stuck transfers with a timeout. It sits between the masters and the bus pins inside the internal bus wrapper.

## Interface
Parameters:
- ADDR_W, 32: address width (ADDR_SIZE0+1).
- DATA_W, 32: data width (DATA_SIZE0+1).
- TIMEOUT, 255: enabled cycles allowed in WAIT before abort; minimum 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- clk_oe  in  1  cycle enable; all registers update only when high.
- bus_busy  in  1  external bus occupied; no new grant while high.
- req  in  3  request per master: bit0 memory, bit1 thread, bit2 channel.
- req_kind  in  6  2 bits per master, master i at [2i+1:2i]: 00 read, 01 write, 1x message.
- req_addr  in  3*ADDR_W  per-master address; master i at [i*ADDR_W +: ADDR_W].
- req_data  in  3*DATA_W  per-master write/message data.
- read_dn  in  1  bus read complete.
- write_dn  in  1  bus write complete.
- gnt  out  3  one-hot grant, or zero.
- done  out  3  one-hot completion pulse.
- timeout_err  out  1  pulse, coincident with done, on timeout abort.
- addr_out  out  ADDR_W  granted master's address; 0 when no read_q/write_q/msg_pulse.
- data_out  out  DATA_W  granted master's data; 0 under the same condition.
- read_q  out  1  bus read request.
- write_q  out  1  bus write request.
- msg_pulse  out  1  one-cycle CPU message strobe.

## Operation
- States: IDLE, WAIT, MSG, RELEASE.
- Reset values:
  - gnt, done, timeout_err, read_q, write_q, msg_pulse, addr_out, data_out are 0.
  - State is IDLE and the timeout counter is 0.
  - The round-robin pointer is 2, so master 0 wins first.
- IDLE:
  - If bus_busy=0 and req≠0, pick the first set req bit, searching from pointer+1 mod 3.
  - Set gnt, load pointer with the winner, clear the counter.
  - Kind 00 sets read_q and goes to WAIT. Kind 01 sets write_q and goes to WAIT. Kind 1x sets msg_pulse and goes to MSG.
- WAIT:
  - Counter increments each enabled cycle.
  - A completion input matching the kind (read_dn for read, write_dn for write) means: clear read_q/write_q and gnt, pulse done[winner], go to RELEASE. A non-matching dn is ignored.
  - If the counter reaches TIMEOUT with no matching dn: pulse done[winner] and timeout_err, drop q and gnt, go to RELEASE.
  - A matching dn in the same cycle as the timeout is a normal completion; timeout_err stays 0.
  - If the granted master drops req: drop q and gnt, go to RELEASE, no done.
- MSG: msg_pulse was high for one enabled cycle; clear it and gnt, pulse done[winner], go to RELEASE.
- RELEASE: one turnaround cycle with all outputs 0, then IDLE. A still-high req is treated as a new request.
- Masters hold req, req_kind, req_addr and req_data stable from request until done. The arbiter muxes them combinationally from gnt.
- clk_oe=0 freezes all state. Pulses therefore last exactly one enabled cycle.

## Timing
- Grant latency is 1 enabled cycle from a sampled req in IDLE.
- Read/write: done is registered 1 cycle after the matching dn.
- Message: gnt+msg_pulse in cycle N, done in N+1, RELEASE in N+2, next grant no earlier than N+3.
- Back-to-back throughput is one message per 3 cycles; a read/write takes dn latency + 3.
- rst mid-transfer returns to reset values on that edge, with no done and no timeout_err.

## Structure
- Shared header `bus_arb_defs.v` (same style as `states.v`) holds:
  - kind encodings: ARB_KIND_READ, ARB_KIND_WRITE, ARB_KIND_MSG;
  - state encodings: ARB_IDLE, ARB_WAIT, ARB_MSG, ARB_RELEASE;
  - master indices: ARB_M_MEM=0, ARB_M_THRD=1, ARB_M_CHAN=2.
- One combinational sub-module, `rr_pick3`, maps (req, pointer) to a one-hot winner. It is reused later for channel-queue arbitration.
- The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates.

## Test plan
- Reset, then req=3'b001 with kind 00, addr 0x40, and read_dn 4 cycles later:
  - gnt=001 and read_q=1 with addr_out=0x40 one cycle after req;
  - done=001 one cycle after read_dn, then RELEASE.
- req=3'b111 held, all messages: grants go 001, 010, 100, 001, each 3 cycles apart, with msg_pulse width 1.
- Write by master 2 with write_dn never asserted and TIMEOUT=8:
  - done=100 and timeout_err=1 after 8 WAIT cycles;
  - write_q drops on that cycle.
- bus_busy=1 with req=010:
  - no grant while bus_busy is high;
  - gnt=010 one cycle after bus_busy falls.
- clk_oe toggling 1/0 during a read: state advances only on enabled edges, and done spans exactly one enabled cycle.
- rst=1 in WAIT with read_q=1: all outputs are 0 next edge; a subsequent req=001 is granted normally.
